kernel_result_reader: RTL and testbench

- Host-side reader that mirrors the kernel-loading path.
- After start, polls the kernel-done word in the banked data scratchpad until it reads 1, then reads a programmed window of data memory and streams it out as 32-bit words over valid/ready.
- Sits between the scratchpad data-memory request port (one master port) and an external result/debug stream sink.

---
 rtl/kernel_result_reader.sv | 191 +++++++++++++++++++
 tb/tb_kernel_result_reader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : kernel_result_reader
//  Description : Host-side result reader. After a start pulse it polls the
//                kernel-done word in the data scratchpad until it reads 1,
//                then reads a programmed window of data memory and streams
//                it out as 32-bit words over a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module kernel_result_reader #(
  parameter int                    ADDR_WIDTH         = 32,
  parameter int                    DATA_MEM_NUM_BANKS = 4,
  parameter logic [ADDR_WIDTH-1:0] DONE_ADDR          = 32'h0001_FC00,
  parameter int                    POLL_INTERVAL      = 16,
  parameter int                    MAX_WORDS_W        = 16,
  localparam int BANK_W = (DATA_MEM_NUM_BANKS > 1) ? $clog2(DATA_MEM_NUM_BANKS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic [MAX_WORDS_W-1:0] num_words_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   mem_req_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [31:0]            mem_rdata_i,
  output logic                   out_valid_o,
  output logic [31:0]            out_data_o,
  output logic [BANK_W-1:0]      out_bank_o,
  output logic                   out_last_o,
  input  logic                   out_ready_i
);

  localparam int GAP_W = $clog2(POLL_INTERVAL + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POLL_REQ  = 3'd1,
    ST_POLL_WAIT = 3'd2,
    ST_POLL_GAP  = 3'd3,
    ST_DUMP_REQ  = 3'd4,
    ST_DUMP_WAIT = 3'd5,
    ST_DRAIN     = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;       // byte address of the next dump word
  logic [MAX_WORDS_W-1:0] num_q, num_d;
  logic [MAX_WORDS_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   out_valid_q, out_valid_d;
  logic [31:0]            out_data_q, out_data_d;
  logic [BANK_W-1:0]      out_bank_q, out_bank_d;
  logic                   out_last_q, out_last_d;

  // State and datapath registers; reset drops everything, including a full output buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      num_q       <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bank_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bank_q  <= out_bank_d;
      out_last_q  <= out_last_d;
    end
  end

  // Next-state logic, memory request generation and output-buffer management.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    num_d       = num_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_bank_d  = out_bank_q;
    out_last_d  = out_last_q;
    busy_o      = (state_q != ST_IDLE);
    done_o      = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;

    // The sink drains the buffer independently of the request sequencing.
    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i & ~ADDR_WIDTH'(3);
          num_d   = num_words_i;
          idx_d   = '0;
          state_d = ST_POLL_REQ;
        end
      end

      ST_POLL_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = DONE_ADDR;
        if (mem_gnt_i) begin
          state_d = ST_POLL_WAIT;
        end
      end

      ST_POLL_WAIT: begin
        if (mem_rvalid_i) begin
          if (mem_rdata_i == 32'h1) begin
            if (num_q == '0) begin
              done_o  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DUMP_REQ;
            end
          end else begin
            gap_d   = '0;
            state_d = ST_POLL_GAP;
          end
        end
      end

      ST_POLL_GAP: begin
        if (gap_q == GAP_W'(POLL_INTERVAL - 1)) begin
          state_d = ST_POLL_REQ;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      ST_DUMP_REQ: begin
        mem_addr_o = addr_q;
        // Only request when the response is guaranteed a free buffer slot.
        // Once raised, the buffer is empty, so the request stays up until granted.
        if (!out_valid_q || out_ready_i) begin
          mem_req_o = 1'b1;
          if (mem_gnt_i) begin
            state_d = ST_DUMP_WAIT;
          end
        end
      end

      ST_DUMP_WAIT: begin
        if (mem_rvalid_i) begin
          out_valid_d = 1'b1;
          out_data_d  = mem_rdata_i;
          // Word interleave across a power-of-two bank count.
          out_bank_d  = addr_q[BANK_W+1:2];
          out_last_d  = (idx_q == num_q - MAX_WORDS_W'(1));
          idx_d       = idx_q + MAX_WORDS_W'(1);
          addr_d      = addr_q + ADDR_WIDTH'(4);
          state_d     = (idx_q == num_q - MAX_WORDS_W'(1)) ? ST_DRAIN : ST_DUMP_REQ;
        end
      end

      ST_DRAIN: begin
        if (out_valid_q && out_ready_i) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_bank_o  = out_bank_q;
  assign out_last_o  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_kernel_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kernel_result_reader
//  Description : Self-checking bench for kernel_result_reader. A memory
//                responder serves polls and dump reads; a reference model
//                queues the expected stream; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_result_reader;

  localparam int          AW   = 32;
  localparam int          NB   = 4;
  localparam logic [31:0] DONE = 32'h0001_FC00;
  localparam int          PI   = 16;
  localparam int          MW   = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  bank;
    logic        last;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [MW-1:0] num_words_i;
  logic          busy_o, done_o, mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i, mem_rvalid_i;
  logic [31:0]   mem_rdata_i;
  logic          out_valid_o;
  logic [31:0]   out_data_o;
  logic [1:0]    out_bank_o;
  logic          out_last_o;
  logic          out_ready_i;

  kernel_result_reader #(
    .ADDR_WIDTH(AW), .DATA_MEM_NUM_BANKS(NB), .DONE_ADDR(DONE),
    .POLL_INTERVAL(PI), .MAX_WORDS_W(MW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .num_words_i(num_words_i),
    .busy_o(busy_o), .done_o(done_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_bank_o(out_bank_o),
    .out_last_o(out_last_o), .out_ready_i(out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc;
  always @(posedge clk_i) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Memory contents, done-word sequence and responder knobs.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] done_seq[$];
  int          gnt_delay = 0;
  int          gnt_wait  = 0;
  bit          pend      = 0;
  logic [31:0] pend_addr;
  bit          hold_resp = 0;
  bit          arm_hold  = 0;
  int          rdy_mode  = 0;   // 0: always ready, 1: random, 2: driven by the test

  // Observations.
  exp_t        sb[$];
  logic [31:0] exp_addrs[$];
  logic [31:0] dump_addrs[$];
  int          poll_times[$];
  int          poll_cnt, done_cnt, done_time, valid_seen, nwords_seen, blocked;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: grant decided mid-cycle, data returned the cycle after grant.
  initial begin
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_gnt_i = 0; mem_rvalid_i = 0;
      if (pend && !hold_resp) begin
        mem_rvalid_i = 1;
        if (pend_addr == DONE) mem_rdata_i = (done_seq.size() > 0) ? done_seq.pop_front() : 32'h1;
        else                   mem_rdata_i = mem.exists(pend_addr) ? mem[pend_addr] : ~pend_addr;
        pend = 0;
      end
      @(negedge clk_i);
      if (mem_req_o && !pend && !rst_i) begin
        if (gnt_wait >= gnt_delay) begin
          mem_gnt_i = 1; pend = 1; pend_addr = mem_addr_o; gnt_wait = 0;
          if (mem_addr_o == DONE) begin
            poll_cnt++; poll_times.push_back(cyc);
          end else begin
            dump_addrs.push_back(mem_addr_o);
            if (arm_hold) hold_resp = 1;
          end
        end else begin
          gnt_wait++;
        end
      end
    end
  end

  // Sink readiness.
  initial begin
    out_ready_i = 1;
    forever begin
      @(posedge clk_i); #1;
      if (rdy_mode == 0)      out_ready_i = 1;
      else if (rdy_mode == 1) out_ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: stream scoreboard, handshake stability and done/busy relation.
  initial begin
    bit          prev_valid = 0, prev_ready = 0, prev_req = 0, prev_gnt = 0, chk_busy = 0;
    exp_t        prev_word, got;
    logic [31:0] prev_addr;
    forever begin
      @(negedge clk_i); #1;
      if (rst_i) begin
        prev_valid = 0; prev_req = 0; chk_busy = 0;
      end else begin
        got = {out_data_o, out_bank_o, out_last_o};
        if (chk_busy) begin
          check("busy_after_done", 128'(busy_o), 128'(0));
          chk_busy = 0;
        end
        if (prev_valid && !prev_ready)
          check("out_hold_stable", {out_valid_o, got}, {1'b1, prev_word});
        if (prev_req && !prev_gnt)
          check("req_addr_held", {mem_req_o, mem_addr_o}, {1'b1, prev_addr});
        if (out_valid_o) valid_seen++;
        if (out_valid_o && out_ready_i) begin
          nwords_seen++;
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_word: got %0h expected none", got);
          end else begin
            check("stream_word", 128'(got), 128'(sb.pop_front()));
          end
        end
        if (out_valid_o && !out_ready_i && mem_req_o && mem_addr_o != DONE) blocked++;
        if (done_o) begin
          done_cnt++; done_time = cyc; chk_busy = 1;
        end
        prev_valid = out_valid_o; prev_ready = out_ready_i; prev_word = got;
        prev_req = mem_req_o; prev_gnt = mem_gnt_i; prev_addr = mem_addr_o;
      end
    end
  end

  // Reference model: expected stream from the window definition, then start pulse.
  task automatic begin_txn(input logic [31:0] base, input int n, input int gdelay);
    logic [31:0] a;
    poll_cnt = 0; done_cnt = 0; valid_seen = 0; nwords_seen = 0; blocked = 0;
    dump_addrs.delete(); poll_times.delete(); exp_addrs.delete();
    gnt_delay = gdelay; gnt_wait = 0;
    for (int i = 0; i < n; i++) begin
      a = (base & ~32'h3) + 32'(4 * i);
      if (!mem.exists(a)) mem[a] = $urandom;
      sb.push_back({mem[a], 2'((a >> 2) % NB), (i == n - 1)});
      exp_addrs.push_back(a);
    end
    @(posedge clk_i); #1;
    start_i = 1; base_addr_i = base; num_words_i = MW'(n);
    @(posedge clk_i); #1;
    start_i = 0; base_addr_i = $urandom; num_words_i = MW'($urandom);
  endtask

  task automatic reset_dut();
    rst_i = 1;
    repeat (3) @(posedge clk_i);
    #1; rst_i = 0; pend = 0; hold_resp = 0; gnt_wait = 0; sb.delete();
  endtask

  task automatic end_txn(input string tag, input int exp_polls);
    for (int k = 0; k < 4000 && done_cnt == 0; k++) @(posedge clk_i);
    check({tag, "_done_seen"}, 128'(done_cnt > 0), 128'(1));
    repeat (3) @(posedge clk_i);
    check({tag, "_done_once"}, 128'(done_cnt), 128'(1));
    check({tag, "_polls"}, 128'(poll_cnt), 128'(exp_polls));
    check({tag, "_sb_empty"}, 128'(sb.size()), 128'(0));
    check({tag, "_no_req_blocked"}, 128'(blocked), 128'(0));
    check({tag, "_dump_count"}, 128'(dump_addrs.size()), 128'(exp_addrs.size()));
    for (int i = 0; i < dump_addrs.size() && i < exp_addrs.size(); i++)
      check({tag, "_dump_addr"}, 128'(dump_addrs[i]), 128'(exp_addrs[i]));
    if (done_cnt == 0) reset_dut();
  endtask

  initial begin
    logic [31:0] b;
    int n, z;
    start_i = 0; base_addr_i = '0; num_words_i = '0;
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_busy",      128'(busy_o),      128'(0));
    check("rst_done",      128'(done_o),      128'(0));
    check("rst_mem_req",   128'(mem_req_o),   128'(0));
    check("rst_mem_addr",  128'(mem_addr_o),  128'(0));
    check("rst_out_valid", 128'(out_valid_o), 128'(0));
    check("rst_out_data",  128'(out_data_o),  128'(0));
    check("rst_out_bank",  128'(out_bank_o),  128'(0));
    check("rst_out_last",  128'(out_last_o),  128'(0));
    @(posedge clk_i); #1; rst_i = 0;

    // Done already set: single poll, four words A0..A3 on banks 0..3.
    for (int i = 0; i < 4; i++) mem[32'(4 * i)] = 32'hA0 + 32'(i);
    begin_txn(32'h0, 4, 0);
    end_txn("basic", 1);

    // Three not-done reads, then done: poll spacing and dump ordering.
    done_seq = '{32'h0, 32'h0, 32'h0};
    begin_txn(32'h200, 3, 0);
    end_txn("poll_gap", 4);
    for (int i = 1; i < poll_times.size(); i++)
      check("poll_spacing", 128'(poll_times[i] - poll_times[i-1]), 128'(PI + 2));

    // Backpressure on word 1 of 3.
    rdy_mode = 2; out_ready_i = 1;
    begin_txn(32'h300, 3, 0);
    for (int k = 0; k < 500 && nwords_seen < 1; k++) @(negedge clk_i);
    @(posedge clk_i); #1; out_ready_i = 0;
    repeat (10) @(posedge clk_i);
    #1; out_ready_i = 1;
    end_txn("backpressure", 1);
    rdy_mode = 0;

    // Zero-length window: done straight after the poll response.
    begin_txn(32'h400, 0, 0);
    end_txn("zero_len", 1);
    check("zero_len_no_valid", 128'(valid_seen), 128'(0));
    if (poll_times.size() > 0)
      check("zero_len_done_time", 128'(done_time), 128'(poll_times[0] + 1));

    // Slow grants and unaligned base.
    begin_txn(32'h106, 3, 5);
    end_txn("gnt_delay", 1);
    check("gnt_delay_first_addr", 128'(exp_addrs[0]), 128'(32'h104));

    // Reset with a dump response outstanding.
    arm_hold = 1;
    begin_txn(32'h40, 4, 0);
    for (int k = 0; k < 500 && !hold_resp; k++) @(posedge clk_i);
    repeat (2) @(posedge clk_i);
    #3; rst_i = 1;
    #1;
    check("rst_async_outputs",
          128'({busy_o, done_o, mem_req_o, mem_addr_o, out_valid_o, out_data_o, out_bank_o, out_last_o}),
          128'(0));
    @(posedge clk_i); #1;
    rst_i = 0; arm_hold = 0; hold_resp = 0; gnt_wait = 0;
    sb.delete(); valid_seen = 0; done_cnt = 0;
    repeat (6) @(posedge clk_i);
    #1;
    check("late_rvalid_no_valid", 128'(valid_seen), 128'(0));
    check("late_rvalid_idle", 128'({busy_o, done_cnt}), 128'(0));
    begin_txn(32'h40, 4, 0);
    end_txn("after_reset", 1);

    // Randomised windows, including an address wrap and odd not-done words.
    rdy_mode = 1;
    for (int it = 0; it < 8; it++) begin
      b = (it == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 3))) : ($urandom & 32'h0000_FFFF);
      n = $urandom_range(1, 8);
      z = $urandom_range(0, 2);
      done_seq.delete();
      for (int j = 0; j < z; j++) begin
        case ($urandom_range(0, 3))
          0:       done_seq.push_back(32'h0);
          1:       done_seq.push_back(32'h2);
          2:       done_seq.push_back(32'hFFFF_FFFF);
          default: done_seq.push_back(32'h100);
        endcase
      end
      begin_txn(b, n, $urandom_range(0, 3));
      end_txn("random", z + 1);
    end
    rdy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
